// File: rtl/adder_seq_pkg.sv
// Shared types and default sizes for the multi-cycle adder.
package adder_seq_pkg;

  localparam int unsigned WidthDefault = 32;
  localparam int unsigned ChunkDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/adder_chunk.sv
// Combinational Chunk-bit ripple adder built from full-adder cells.
// Also exposes the carry into the slice MSB so the caller can form signed overflow.
module adder_chunk
  import adder_seq_pkg::*;
#(
  parameter int unsigned Chunk = ChunkDefault
) (
  input  logic [Chunk-1:0] a_i,
  input  logic [Chunk-1:0] b_i,
  input  logic             cin_i,
  output logic [Chunk-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [Chunk:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < Chunk; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[Chunk];
  assign cmsb_o = carry[Chunk - 1];

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock with a registered inter-chunk carry.
// Define ADDER_SEQ_SUB_EN to add the sub port (a - b via inverted b and carry-in of 1).
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned CHUNK = ChunkDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [31:0]      lsb;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout, slice_cmsb;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             accept;

`ifdef ADDER_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign lsb    = 32'(idx_q) * CHUNK;
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  adder_chunk #(
    .Chunk(CHUNK)
  ) u_chunk (
    .a_i   (a_q[lsb +: CHUNK]),
    .b_i   (b_q[lsb +: CHUNK]),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout),
    .cmsb_o(slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        sum_d[lsb +: CHUNK] = slice_sum;
        carry_d             = slice_cout;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start in DONE restarts immediately; done is already high this cycle.
    if (accept) begin
      a_d     = a;
      b_d     = b_in;
      carry_d = c_in;
      sum_d   = '0;
      idx_d   = '0;
      busy_d  = 1'b1;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: directed cases plus random operands against an
// arithmetic reference. Define ADDER_SEQ_SUB_EN to also exercise subtraction.
module tb_adder_seq;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  adder_seq #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef ADDER_SEQ_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         co, ov;
    if (sb) begin
      s  = x - y;
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    end
    return {ov, co, s};
  endfunction

  logic [W-1:0] last_sum;

  // Starts an operation in the current cycle and returns in its DONE cycle.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input logic os, input string tag);
    logic [W+1:0] exp;
    logic         os_eff;
`ifdef ADDER_SEQ_SUB_EN
    os_eff = os;
`else
    os_eff = 1'b0;
`endif
    exp   = model(oa, ob, oc, os_eff);
    start = 1'b1;
    a     = oa;
    b     = ob;
    cin   = oc;
    sub   = os_eff;
    step();
    for (int i = 1; i <= N; i++) begin
      // Operands and start are don't-care while running.
      start = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      check({tag, " busy"}, busy, 1);
      check({tag, " no_done"}, done, 0);
      step();
    end
    start = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " sum"}, sum, exp[W-1:0]);
    check({tag, " cout"}, cout, exp[W]);
    check({tag, " ovf"}, ovf, exp[W+1]);
    last_sum = exp[W-1:0];
  endtask

  task automatic go_idle(input string tag);
    step();
    check({tag, " idle_done"}, done, 0);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " hold_sum"}, sum, last_sum);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    step();
    step();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
    check("rst ovf", ovf, 0);
    rst = 1'b0;
    step();

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "ff_plus_1");
    check("ff_plus_1 exact", sum, 32'h0000_0100);
    go_idle("ff_plus_1");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
    check("wrap exact", sum, 32'h0000_0000);
    go_idle("wrap");
    do_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "ovf_cin");
    check("ovf_cin exact", ovf, 1);
    go_idle("ovf_cin");

    // Start during RUN is ignored; only one done results.
    start = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    check("ign done t3", done, 0);
    step();
    check("ign done t4", done, 0);
    step();
    check("ign done t5", done, 1);
    check("ign sum", sum, 32'h0000_0003);
    do_op(32'd4, 32'd4, 1'b0, 1'b0, "b2b");
    check("b2b exact", sum, 32'h0000_0008);
    go_idle("b2b");

    // Reset mid-operation aborts with no done pulse.
    start = 1'b1; a = 32'h1234_5678; b = 32'd1; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort sum", sum, 0);
    check("abort done", done, 0);
    for (int i = 0; i < N + 2; i++) begin
      step();
      check("abort no_done", done, 0);
      check("abort no_busy", busy, 0);
    end
    last_sum = '0;

`ifdef ADDER_SEQ_SUB_EN
    do_op(32'd5, 32'd7, 1'b0, 1'b1, "sub_5_7");
    check("sub_5_7 exact", sum, 32'hFFFF_FFFE);
    go_idle("sub_5_7");
    do_op(32'd7, 32'd5, 1'b1, 1'b1, "sub_7_5");
    check("sub_7_5 exact", sum, 32'h0000_0002);
    go_idle("sub_7_5");
    do_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, "sub_ovf");
    check("sub_ovf exact", ovf, 1);
    go_idle("sub_ovf");
`endif

    for (int n = 0; n < 16; n++) begin
      do_op($urandom, $urandom, 1'($urandom), 1'($urandom), "rand");
      if ($urandom_range(1, 0) == 1) go_idle("rand");
    end
    go_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
# adder_seq

Parametrised multi-cycle N-bit adder for the ALU datapath. It processes the operands CHUNK bits per clock, with a registered carry between chunks, so wide adds close timing with a short ripple path. It is controlled by a start/busy/done handshake and reports carry-out and signed overflow. It sits between the operand registers and the ALU result mux.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per cycle; NCHUNK = WIDTH/CHUNK, at least 1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- sub  input  1  subtract select; present only with ADDER_SEQ_SUB_EN.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, chunk index=0, carry register=0.
- IDLE, start=1: capture a, b and cin (and sub), clear sum, set index=0, load carry register with cin, go to RUN.
- RUN, each cycle:
  - Add a[idx] + b[idx] + carry, where [idx] is the CHUNK-bit slice idx.
  - Write the slice sum into sum[idx] and store the slice carry-out.
  - idx increments; at idx=NCHUNK-1, also latch cout and ovf and go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE. If start=1 in DONE, go directly to RUN with new operands; done still pulses in that cycle.
- start in RUN is ignored. It is not queued and the operands are not recaptured.
- sum, cout and ovf hold their values from DONE until the next accepted start. During RUN, sum is partially updated and is not valid.
- Input operands may change freely after capture.
- rst during RUN or DONE aborts the operation:
  - All outputs return to their reset values the next cycle.
  - No done pulse is produced.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- start accepted in cycle t: busy=1 in cycles t+1 .. t+NCHUNK; done=1 and busy=0 in cycle t+NCHUNK+1.
- Latency is NCHUNK+1 cycles; for the defaults, done is in cycle t+5.
- Throughput is one result per NCHUNK+1 cycles with back-to-back start in DONE.
- The critical path is one CHUNK-bit ripple plus the carry register setup.
- done and busy are never high in the same cycle.

## Configuration
- ADDER_SEQ_SUB_EN defined:
  - The sub port exists.
  - With sub=1, the captured b is bitwise inverted and the initial carry is 1; cin is ignored. The result is a-b.
  - cout=1 means no borrow. ovf is the signed subtraction overflow.
- ADDER_SEQ_SUB_EN undefined:
  - There is no sub port or inversion logic; the block always computes a+b+cin.

## Structure
- Package adder_seq_pkg contains:
  - The state enum typedef (IDLE, RUN, DONE).
  - The WIDTH and CHUNK defaults.
- Sub-module adder_chunk: a combinational CHUNK-bit ripple adder built from full-adder cells. Outputs are the slice sum, the carry out, and the carry into the slice MSB (used for ovf).
- The top level holds the FSM, the chunk index counter, the carry register, and the operand/result registers. Slices are selected with an indexed part-select.

## Test plan
- Defaults, a=0x0000_00FF, b=0x0000_0001, cin=0 -> sum=0x0000_0100, cout=0, ovf=0, done in cycle t+5, busy high for cycles t+1..t+4.
- a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1, ovf=0. This checks carry propagation across all chunk boundaries.
- a=0x7FFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x8000_0000, cout=0, ovf=1.
- start with a=1, b=2, then start with a=9, b=9 in cycle t+2 -> single done, sum=0x0000_0003. Then start asserted in the DONE cycle with a=4, b=4 -> second done in that cycle+5, sum=0x0000_0008.
- start with a=0x1234_5678, b=1; rst pulsed in cycle t+2 -> no done pulse; busy=0 and sum=0 from cycle t+3.
- With ADDER_SEQ_SUB_EN, sub=1:
  - a=5, b=7 -> sum=0xFFFF_FFFE, cout=0.
  - a=7, b=5 -> sum=0x0000_0002, cout=1.
  - a=0x8000_0000, b=1 -> ovf=1.
